// File: rtl/ras_checkpointed_pkg.sv
// Shared types for the checkpointed return address stack.
package ras_checkpointed_pkg;

  // Default configuration of the fetch-stage return address stack.
  localparam int RAS_DEPTH   = 16;
  localparam int PC_WIDTH    = 32;
  localparam int FETCH_WIDTH = 2;

  typedef logic [$clog2(RAS_DEPTH)-1:0] ras_index_t;
  typedef logic [PC_WIDTH-1:0]          pc_t;

  // Checkpoint carried down the pipeline with each predicted call/return.
  typedef struct packed {
    ras_index_t ptr;
    pc_t        top;
  } ras_checkpoint_t;

  // Stack operation requested by the active fetch lane.
  typedef enum logic [1:0] {
    RAS_NONE    = 2'd0,
    RAS_PUSH    = 2'd1,
    RAS_POP     = 2'd2,
    RAS_POPPUSH = 2'd3
  } ras_action_e;

  // Map the call/return flags of one lane onto a stack operation.
  function automatic ras_action_e decode_action(input logic is_push, input logic is_pop);
    ras_action_e act;
    case ({is_push, is_pop})
      2'b10:   act = RAS_PUSH;
      2'b01:   act = RAS_POP;
      2'b11:   act = RAS_POPPUSH;
      default: act = RAS_NONE;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ras_checkpointed_storage.sv
// Entry array of the return address stack: one asynchronous read port and
// one write port. Entries clear on reset so a fresh stack reads as zero.
module ras_checkpointed_storage #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DEPTH-1:0][DATA_W-1:0] entry_q;
  logic [DEPTH-1:0][DATA_W-1:0] entry_d;

  // Next contents: only the addressed entry changes on a write.
  always_comb begin
    entry_d = entry_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (waddr == IDX_W'(i))) begin
        entry_d[i] = wdata;
      end
    end
  end

  // Entry registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign rdata = entry_q[raddr];

endmodule

// File: rtl/ras_checkpointed.sv
// Checkpointed return address stack for the fetch stage. The first valid
// call/return lane in the fetch group drives the stack; a backend recovery
// restores the top pointer and the single top entry in one cycle.
module ras_checkpointed #(
  parameter int FETCH_WIDTH = ras_checkpointed_pkg::FETCH_WIDTH,
  parameter int RAS_DEPTH   = ras_checkpointed_pkg::RAS_DEPTH,
  parameter int PC_WIDTH    = ras_checkpointed_pkg::PC_WIDTH,
  parameter int IDX_W       = $clog2(RAS_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [FETCH_WIDTH-1:0]               fetchStageIsValid,
  input  logic [FETCH_WIDTH-1:0]               readIsRASPushBr,
  input  logic [FETCH_WIDTH-1:0]               readIsRASPopBr,
  input  logic [FETCH_WIDTH-1:0][PC_WIDTH-1:0] pushAddr,
  input  logic                                 stall,
  input  logic                                 recoverValid,
  input  logic [IDX_W-1:0]                     recoverPtr,
  input  logic [PC_WIDTH-1:0]                  recoverTop,
  output logic [FETCH_WIDTH-1:0][PC_WIDTH-1:0] rasOut,
  output logic [IDX_W-1:0]                     ckptPtr,
  output logic [PC_WIDTH-1:0]                  ckptTop
);

  import ras_checkpointed_pkg::*;

  logic [IDX_W-1:0]    top_ptr_q;
  logic [IDX_W-1:0]    top_ptr_d;
  logic [IDX_W-1:0]    ptr_inc;
  logic [IDX_W-1:0]    ptr_dec;
  logic [PC_WIDTH-1:0] top_data;

  logic                act_found;
  logic                act_push;
  logic                act_pop;
  logic [PC_WIDTH-1:0] act_addr;
  ras_action_e         action;

  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  logic [PC_WIDTH-1:0] wr_data;

  // Priority encoder: the lowest valid lane flagged as call or return wins,
  // since the fetch group ends at that branch.
  always_comb begin
    act_found = 1'b0;
    act_push  = 1'b0;
    act_pop   = 1'b0;
    act_addr  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!act_found && fetchStageIsValid[i] &&
          (readIsRASPushBr[i] || readIsRASPopBr[i])) begin
        act_found = 1'b1;
        act_push  = readIsRASPushBr[i];
        act_pop   = readIsRASPopBr[i];
        act_addr  = pushAddr[i];
      end
    end
  end

  assign action  = decode_action(act_push, act_pop);
  assign ptr_inc = top_ptr_q + IDX_W'(1);
  assign ptr_dec = top_ptr_q - IDX_W'(1);

  // Next-state: recovery beats stall and any fetch action; pointer wraps
  // naturally so overflow overwrites the oldest entry.
  always_comb begin
    top_ptr_d = top_ptr_q;
    wr_en     = 1'b0;
    wr_addr   = top_ptr_q;
    wr_data   = act_addr;
    if (recoverValid) begin
      top_ptr_d = recoverPtr;
      wr_en     = 1'b1;
      wr_addr   = recoverPtr;
      wr_data   = recoverTop;
    end else if (!stall) begin
      case (action)
        RAS_PUSH: begin
          top_ptr_d = ptr_inc;
          wr_en     = 1'b1;
          wr_addr   = ptr_inc;
        end
        RAS_POP: begin
          top_ptr_d = ptr_dec;
        end
        RAS_POPPUSH: begin
          // Return and call in one instruction: replace the top in place.
          wr_en   = 1'b1;
          wr_addr = top_ptr_q;
        end
        default: begin
        end
      endcase
    end
  end

  // Top pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_ptr_q <= '0;
    end else begin
      top_ptr_q <= top_ptr_d;
    end
  end

  ras_checkpointed_storage #(
    .DEPTH  (RAS_DEPTH),
    .DATA_W (PC_WIDTH),
    .IDX_W  (IDX_W)
  ) u_storage (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (top_ptr_q),
    .rdata (top_data)
  );

  // Every lane sees the same predicted return target.
  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane_out
    assign rasOut[gi] = top_data;
  end

  assign ckptPtr = top_ptr_q;
  assign ckptTop = top_data;

endmodule

// File: tb/tb_ras_checkpointed.sv
// Directed bench for the checkpointed RAS: a depth-16 and a depth-4 instance
// share the stimulus; a reference stack model feeds a scoreboard queue and
// directed constants pin the values called out for each scenario.
module tb_ras_checkpointed;

  logic              clk;
  logic              rst;
  logic [1:0]        valid;
  logic [1:0]        is_push;
  logic [1:0]        is_pop;
  logic [1:0][31:0]  paddr;
  logic              stall;
  logic              rec_valid;
  logic [3:0]        rec_ptr;
  logic [31:0]       rec_top;

  logic [1:0][31:0]  ras_out16;
  logic [3:0]        ckpt_ptr16;
  logic [31:0]       ckpt_top16;
  logic [1:0][31:0]  ras_out4;
  logic [1:0]        ckpt_ptr4;
  logic [31:0]       ckpt_top4;

  int passed = 0;
  int total  = 0;
  int step_no = 0;

  // Reference model: index 0 is the depth-16 stack, index 1 the depth-4 one.
  logic [31:0] m_ent [2][16];
  int          m_ptr [2];
  int          m_depth [2] = '{16, 4};

  typedef struct {
    int          step;
    logic [31:0] ptr16;
    logic [31:0] top16;
    logic [31:0] ptr4;
    logic [31:0] top4;
  } exp_t;
  exp_t sb[$];

  ras_checkpointed #(.FETCH_WIDTH(2), .RAS_DEPTH(16), .PC_WIDTH(32)) dut16 (
    .clk(clk), .rst(rst), .fetchStageIsValid(valid), .readIsRASPushBr(is_push),
    .readIsRASPopBr(is_pop), .pushAddr(paddr), .stall(stall),
    .recoverValid(rec_valid), .recoverPtr(rec_ptr), .recoverTop(rec_top),
    .rasOut(ras_out16), .ckptPtr(ckpt_ptr16), .ckptTop(ckpt_top16)
  );

  ras_checkpointed #(.FETCH_WIDTH(2), .RAS_DEPTH(4), .PC_WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .fetchStageIsValid(valid), .readIsRASPushBr(is_push),
    .readIsRASPopBr(is_pop), .pushAddr(paddr), .stall(stall),
    .recoverValid(rec_valid), .recoverPtr(rec_ptr[1:0]), .recoverTop(rec_top),
    .rasOut(ras_out4), .ckptPtr(ckpt_ptr4), .ckptTop(ckpt_top4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0;
      for (int j = 0; j < 16; j++) m_ent[k][j] = 32'h0;
    end
  endtask

  // Apply this cycle's inputs to one model stack (effect at the next edge).
  task automatic model_step(input int k);
    int d;
    int lane;
    d = m_depth[k];
    lane = -1;
    for (int i = 1; i >= 0; i--)
      if (valid[i] && (is_push[i] || is_pop[i])) lane = i;
    if (rec_valid) begin
      m_ptr[k] = int'(rec_ptr) % d;
      m_ent[k][m_ptr[k]] = rec_top;
    end else if (!stall && lane >= 0) begin
      if (is_push[lane] && is_pop[lane]) begin
        m_ent[k][m_ptr[k]] = paddr[lane];
      end else if (is_push[lane]) begin
        m_ptr[k] = (m_ptr[k] + 1) % d;
        m_ent[k][m_ptr[k]] = paddr[lane];
      end else begin
        m_ptr[k] = (m_ptr[k] + d - 1) % d;
      end
    end
  endtask

  // One fetch cycle: drive inputs, queue the expected outputs for the
  // current state, compare them, then advance the model.
  task automatic drive(input logic [1:0] v, input logic [1:0] pu, input logic [1:0] po,
                       input logic [31:0] a0, input logic [31:0] a1, input logic st,
                       input logic rv, input logic [3:0] rp, input logic [31:0] rt,
                       input logic r);
    exp_t e;
    exp_t g;
    @(negedge clk);
    valid = v; is_push = pu; is_pop = po; paddr[0] = a0; paddr[1] = a1;
    stall = st; rec_valid = rv; rec_ptr = rp; rec_top = rt; rst = r;
    step_no++;
    e.step  = step_no;
    e.ptr16 = 32'(m_ptr[0]);
    e.top16 = m_ent[0][m_ptr[0]];
    e.ptr4  = 32'(m_ptr[1]);
    e.top4  = m_ent[1][m_ptr[1]];
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    check("sb_ras16_l0", ras_out16[0], g.top16);
    check("sb_ras16_l1", ras_out16[1], g.top16);
    check("sb_ckptptr16", 32'(ckpt_ptr16), g.ptr16);
    check("sb_ckpttop16", ckpt_top16, g.top16);
    check("sb_ras4_l0", ras_out4[0], g.top4);
    check("sb_ckptptr4", 32'(ckpt_ptr4), g.ptr4);
    check("sb_ckpttop4", ckpt_top4, g.top4);
    $display("step %0d v=%b push=%b pop=%b st=%b rv=%b rst=%b | ptr16=%0d top16=%h ptr4=%0d top4=%h",
             g.step, v, pu, po, st, rv, r, ckpt_ptr16, ckpt_top16, ckpt_ptr4, ckpt_top4);
    if (r) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
  endtask

  task automatic push0(input logic [31:0] a);
    drive(2'b01, 2'b01, 2'b00, a, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
  endtask

  task automatic pop0();
    drive(2'b01, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
  endtask

  logic [31:0] pop_exp4 [5] = '{32'h50, 32'h40, 32'h30, 32'h20, 32'h50};
  localparam logic [31:0] CK_PTR = 32'd2;
  localparam logic [31:0] CK_TOP = 32'h200;

  initial begin
    rst = 1'b1; valid = '0; is_push = '0; is_pop = '0; paddr = '0;
    stall = 1'b0; rec_valid = 1'b0; rec_ptr = '0; rec_top = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state.
    idle();
    check("reset_rasout", ras_out16[1], 32'h0);
    check("reset_ckptptr", 32'(ckpt_ptr16), 32'd0);

    // Three pushes then three pops.
    push0(32'h100); push0(32'h200); push0(32'h300);
    idle();
    check("push3_rasout", ras_out16[0], 32'h300);
    check("push3_ckptptr", 32'(ckpt_ptr16), 32'd3);
    pop0(); check("pop1_rasout", ras_out16[0], 32'h300);
    pop0(); check("pop2_rasout", ras_out16[0], 32'h200);
    pop0(); check("pop3_rasout", ras_out16[0], 32'h100);
    idle(); check("pop3_ptr", 32'(ckpt_ptr16), 32'd0);

    // Invalid pop on lane 0, valid push on lane 1.
    drive(2'b10, 2'b10, 2'b01, 32'h0, 32'h400, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    idle();
    check("lane1_ptr", 32'(ckpt_ptr16), 32'd1);
    check("lane1_rasout", ras_out16[0], 32'h400);

    // Stalled push has no effect.
    drive(2'b01, 2'b01, 2'b00, 32'h999, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0);
    idle();
    check("stall_ptr", 32'(ckpt_ptr16), 32'd1);

    // Pop+push replaces the top in place.
    push0(32'h200);
    drive(2'b01, 2'b01, 2'b01, 32'h500, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    check("poppush_old", ras_out16[0], 32'h200);
    idle();
    check("poppush_new", ras_out16[0], 32'h500);
    check("poppush_ptr", 32'(ckpt_ptr16), 32'd2);

    // Checkpoint, speculate, then recover with a stalled push in flight.
    pop0(); push0(32'h200);
    idle();
    check("ckpt_ptr", 32'(ckpt_ptr16), CK_PTR);
    check("ckpt_top", ckpt_top16, CK_TOP);
    push0(32'h600); pop0(); pop0();
    drive(2'b01, 2'b01, 2'b00, 32'h700, 32'h0, 1'b1, 1'b1, CK_PTR[3:0], CK_TOP, 1'b0);
    idle();
    check("recover_ptr", 32'(ckpt_ptr16), 32'd2);
    check("recover_rasout", ras_out16[0], 32'h200);

    // Reset beats recovery in the same cycle.
    drive(2'b01, 2'b01, 2'b00, 32'h800, 32'h0, 1'b0, 1'b1, 4'd5, 32'habc, 1'b1);
    idle();
    check("rst_rec_ptr", 32'(ckpt_ptr16), 32'd0);
    check("rst_rec_rasout", ras_out16[0], 32'h0);

    // Depth-4 overflow and underflow wrap.
    for (int n = 1; n <= 5; n++) push0(32'(n * 16));
    for (int n = 0; n < 5; n++) begin
      pop0();
      check("wrap4_pop", ras_out4[0], pop_exp4[n]);
    end
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ras_checkpointed.md
# ras_checkpointed

Parametrised, checkpointed return address stack for the fetch stage. Serves one lookup per cycle across a `FETCH_WIDTH`-lane fetch group, where the first lane flagged by the BTB as a push or pop branch determines the action. Also supplies each predicted call/return with a checkpoint, and repairs the stack in one cycle when the backend signals a misprediction. It replaces the fixed-depth RAS behind the fetch interface's `RAS` modport, adding configurable depth, combined pop+push, stall and recovery.

## Interface
- `FETCH_WIDTH`, 2: lanes per fetch group.
- `RAS_DEPTH`, 16: entries. Must be a power of two, ≥ 2.
- `PC_WIDTH`, 32: width of return addresses.
- `clk` in 1: clock. The block uses one clock.
- `rst` in 1: reset. Synchronous, active-high.
- `fetchStageIsValid` in `FETCH_WIDTH`×1: lane valid.
- `readIsRASPushBr` in `FETCH_WIDTH`×1: lane is a call.
- `readIsRASPopBr` in `FETCH_WIDTH`×1: lane is a return.
- `pushAddr` in `FETCH_WIDTH`×`PC_WIDTH`: return address for each lane (lane PC + 4).
- `stall` in 1: fetch stalled; no speculative update.
- `recoverValid` in 1: misprediction repair request.
- `recoverPtr` in log2(`RAS_DEPTH`): checkpointed top pointer.
- `recoverTop` in `PC_WIDTH`: checkpointed top value.
- `rasOut` in/out? No — `rasOut` out `FETCH_WIDTH`×`PC_WIDTH`: predicted return target, the current top value on every lane.
- `ckptPtr` out log2(`RAS_DEPTH`): top pointer before this cycle's update.
- `ckptTop` out `PC_WIDTH`: top value before this cycle's update.

## Operation
- **State:** `entry[RAS_DEPTH]` and `topPtr`, which indexes the valid top entry. Reset values: `topPtr` = 0 and every entry = 0. As a result, after reset `rasOut` = 0 on all lanes, `ckptPtr` = 0 and `ckptTop` = 0.
- **Active lane:** the lowest index `i` with `fetchStageIsValid[i]` and (`readIsRASPushBr[i]` or `readIsRASPopBr[i]`). Later lanes are ignored, because the group ends at that branch.
- **Action of the active lane:**
  - Push only: `topPtr` ← `topPtr`+1 mod `RAS_DEPTH`; `entry[new ptr]` ← `pushAddr[i]`.
  - Pop only: `topPtr` ← `topPtr`−1 mod `RAS_DEPTH`. The entry is not cleared.
  - Pop and push (coroutine-style jalr): `rasOut` gives the old top; `entry[topPtr]` ← `pushAddr[i]`; `topPtr` is unchanged.
- **Overflow:** a push when the stack is full wraps and overwrites the oldest entry. There is no flag and no error.
- **Underflow:** a pop when the stack is empty wraps and returns a stale or zero value. There is no flag.
- **Stall:** when `stall`=1, no speculative update occurs. Outputs still reflect the current state.
- **Recovery:** when `recoverValid`=1, `topPtr` ← `recoverPtr` and `entry[recoverPtr]` ← `recoverTop`.
  - Recovery has priority over any fetch action and over `stall` in the same cycle; that cycle's fetch action is discarded.
  - Other entries are not restored. Single-entry repair is the decided accuracy trade-off.
- **Checkpoint:** `ckptPtr` and `ckptTop` are `topPtr` and `entry[topPtr]` as they stand at the start of the cycle. The fetch pipeline stores them with the branch.
- **Arithmetic:** all pointer arithmetic is unsigned, log2(`RAS_DEPTH`) bits wide, and wraps naturally.

## Timing
- `rasOut`, `ckptPtr` and `ckptTop` are combinational from registered state. They are valid in the same cycle as the BTB lookup.
- Updates (push, pop, recover) take effect at the next `clk` edge and are visible in the following cycle: one-cycle latency.
- Recovery completes in one cycle. The fetch stream redirected in the cycle after `recoverValid` sees the repaired top.
- There is no handshake. Inputs are sampled every cycle and qualified only by the valid signals, `stall` and `rst`.
- Reset mid-operation: `rst` high at an edge overrides recovery and fetch actions; all state returns to its reset values at that edge.

## Structure
- Add to `FetchUnitTypes`:
  - `RAS_DEPTH` constant.
  - `RAS_IndexPath` (log2 depth bits).
  - `RAS_CheckpointPath` struct {`RAS_IndexPath ptr`; `PC_Path top`}, carried in the pipeline registers alongside `brGlobalHistory`.
- Sub-module `ras_storage`: entry array with one asynchronous read port (at `topPtr`) and one write port. Push and recover writes never conflict because recovery wins and suppresses the push, so the top block only muxes the write address and data.
- Top-level `ras_checkpointed` contains the active-lane priority encoder, the pointer register and the next-state logic.

## Test plan
- Reset, then 3 pushes of 0x100, 0x200 and 0x300 on lane 0 in consecutive cycles → `rasOut` = 0x300 and `ckptPtr` = 3. Then 3 pops → `rasOut` = 0x300, 0x200, 0x100 in turn, and `topPtr` = 0.
- Same cycle: lane 0 carries a pop with valid=0, and lane 1 carries a push of 0x400 with valid=1 → only the push occurs; `ckptPtr` advances by 1.
- Lane 0 flagged as both pop and push with `pushAddr` = 0x500 while the top is 0x200 → `rasOut` = 0x200 this cycle; the next cycle `rasOut` = 0x500 with `topPtr` unchanged.
- With `RAS_DEPTH` = 4, push 5 times (0x10 through 0x50), then pop 4 times → pops return 0x50, 0x40, 0x30, 0x20; the 5th pop returns 0x50 (wrapped, stale).
- Record the checkpoint {2, 0x200}, push 0x600, pop twice, then assert `recoverValid` with {2, 0x200} in the same cycle as a push with `stall`=1 → the next cycle has `topPtr` = 2 and `rasOut` = 0x200; the push is discarded.
- Assert `rst` in the same cycle as `recoverValid` → the next cycle has `topPtr` = 0 and `rasOut` = 0.
